// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates branch ops against flags/rs_val and
// drives the registered fetch redirect, wrong-path flush, link write and taken count.
module branch_resolve_unit #(
    parameter int AW           = 10,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [AW-1:0]     id_ex_NPC,
    input  logic [3:0]        br_op,
    input  logic [AW-1:0]     br_offset,
    input  logic [31:0]       rs_val,
    input  logic              alu_flag_we,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic              PCSrc,
    output logic [AW-1:0]     Ex_NPC,
    output logic              flush,
    output logic              link_we,
    output logic [AW-1:0]     link_data,
    output logic [2:0]        flags,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_BR   = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_BL   = 4'd6;
    localparam logic [3:0] OP_BCY  = 4'd7;
    localparam logic [3:0] OP_BNCY = 4'd8;

    localparam logic [2:0] SQ_LOAD = 3'(FLUSH_CYCLES);

    logic              pcsrc_q,   pcsrc_d;
    logic [AW-1:0]     ex_npc_q,  ex_npc_d;
    logic [2:0]        sq_q,      sq_d;
    logic              link_we_q, link_we_d;
    logic [AW-1:0]     link_q,    link_d;
    logic [2:0]        flags_q,   flags_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              act;
    logic              taken;
    logic [AW-1:0]     target;

    always_comb begin
        act    = valid_in & (sq_q == 3'd0);
        taken  = 1'b0;
        target = id_ex_NPC + br_offset;
        if (br_op == OP_BR) begin
            target = rs_val[AW-1:0];
        end

        // Carry is flags_q[2]; the registered value is used even if an ALU
        // op updates flags in the same cycle.
        case (br_op)
            OP_B, OP_BR, OP_BL: taken = 1'b1;
            OP_BLTZ:            taken = rs_val[31];
            OP_BZ:              taken = (rs_val == 32'd0);
            OP_BNZ:             taken = (rs_val != 32'd0);
            OP_BCY:             taken = flags_q[2];
            OP_BNCY:            taken = ~flags_q[2];
            default:            taken = 1'b0;
        endcase

        pcsrc_d   = 1'b0;
        link_we_d = 1'b0;
        ex_npc_d  = ex_npc_q;
        link_d    = link_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        sq_d      = (sq_q != 3'd0) ? sq_q - 3'd1 : 3'd0;

        if (act && taken) begin
            pcsrc_d  = 1'b1;
            ex_npc_d = target;
            sq_d     = SQ_LOAD;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (act && (br_op == OP_BL)) begin
            link_we_d = 1'b1;
            link_d    = id_ex_NPC;
        end

        if (act && alu_flag_we) begin
            flags_d = {alu_carry, alu_zero, alu_sign};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcsrc_q   <= 1'b0;
            ex_npc_q  <= '0;
            sq_q      <= 3'd0;
            link_we_q <= 1'b0;
            link_q    <= '0;
            flags_q   <= 3'd0;
            cnt_q     <= '0;
        end else begin
            pcsrc_q   <= pcsrc_d;
            ex_npc_q  <= ex_npc_d;
            sq_q      <= sq_d;
            link_we_q <= link_we_d;
            link_q    <= link_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PCSrc     = pcsrc_q;
    assign Ex_NPC    = ex_npc_q;
    assign flush     = (sq_q != 3'd0);
    assign link_we   = link_we_q;
    assign link_data = link_q;
    assign flags     = flags_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after each edge.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [9:0]  id_ex_NPC;
    logic [3:0]  br_op;
    logic [9:0]  br_offset;
    logic [31:0] rs_val;
    logic        alu_flag_we, alu_carry, alu_zero, alu_sign;

    logic        PCSrc, flush, link_we;
    logic [9:0]  Ex_NPC, link_data;
    logic [2:0]  flags;
    logic [15:0] taken_cnt;

    logic        pcsrc_s, flush_s, link_we_s;
    logic [9:0]  ex_npc_s, link_data_s;
    logic [2:0]  flags_s;
    logic [3:0]  taken_cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.AW(10), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .id_ex_NPC(id_ex_NPC),
        .br_op(br_op), .br_offset(br_offset), .rs_val(rs_val),
        .alu_flag_we(alu_flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .PCSrc(PCSrc), .Ex_NPC(Ex_NPC), .flush(flush),
        .link_we(link_we), .link_data(link_data), .flags(flags),
        .taken_cnt(taken_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    branch_resolve_unit #(.AW(10), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .id_ex_NPC(id_ex_NPC),
        .br_op(br_op), .br_offset(br_offset), .rs_val(rs_val),
        .alu_flag_we(alu_flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .PCSrc(pcsrc_s), .Ex_NPC(ex_npc_s), .flush(flush_s),
        .link_we(link_we_s), .link_data(link_data_s), .flags(flags_s),
        .taken_cnt(taken_cnt_s)
    );

    typedef struct {
        logic        pc;
        logic [9:0]  ex;
        logic        fl;
        logic        lwe;
        logic [9:0]  ld;
        logic [2:0]  fg;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t sb[$];

    int          m_sq = 0;
    logic        m_pc = 0, m_lwe = 0;
    logic [9:0]  m_ex = '0, m_ld = '0;
    logic [2:0]  m_fg = '0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_cnt_s = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] op,
                        input logic [9:0] npc, input logic [9:0] off,
                        input logic [31:0] rs, input logic fwe,
                        input logic c, input logic z, input logic s);
        logic act, tk;
        logic [9:0] tgt;
        exp_t e;
        rst = r; valid_in = v; br_op = op; id_ex_NPC = npc; br_offset = off;
        rs_val = rs; alu_flag_we = fwe; alu_carry = c; alu_zero = z; alu_sign = s;
        if (!r) begin
            m_sq = 0; m_pc = 0; m_lwe = 0; m_ex = '0; m_ld = '0;
            m_fg = '0; m_cnt = '0; m_cnt_s = '0;
        end else begin
            act = v && (m_sq == 0);
            case (op)
                4'd1, 4'd2, 4'd6: tk = 1'b1;
                4'd3: tk = rs[31];
                4'd4: tk = (rs == 0);
                4'd5: tk = (rs != 0);
                4'd7: tk = m_fg[2];
                4'd8: tk = !m_fg[2];
                default: tk = 1'b0;
            endcase
            tgt = (op == 4'd2) ? rs[9:0] : 10'((npc + off) % 1024);
            m_pc = 0; m_lwe = 0;
            if (m_sq > 0) m_sq--;
            if (act && tk) begin
                m_pc = 1; m_ex = tgt; m_sq = 2;
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (m_cnt_s != 4'hF) m_cnt_s++;
            end
            if (act && op == 4'd6) begin m_lwe = 1; m_ld = npc; end
            if (act && fwe) m_fg = {c, z, s};
        end
        e.pc = m_pc; e.ex = m_ex; e.fl = (m_sq != 0); e.lwe = m_lwe; e.ld = m_ld;
        e.fg = m_fg; e.cnt = m_cnt; e.cnt_s = m_cnt_s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("PCSrc", 32'(PCSrc), 32'(e.pc));
            chk("Ex_NPC", 32'(Ex_NPC), 32'(e.ex));
            chk("flush", 32'(flush), 32'(e.fl));
            chk("link_we", 32'(link_we), 32'(e.lwe));
            chk("link_data", 32'(link_data), 32'(e.ld));
            chk("flags", 32'(flags), 32'(e.fg));
            chk("taken_cnt", 32'(taken_cnt), 32'(e.cnt));
            chk("taken_cnt_sat", 32'(taken_cnt_s), 32'(e.cnt_s));
        end
    endtask

    task automatic idle();
        step(1, 0, 4'd0, 10'd0, 10'd0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic brn(input logic [3:0] op, input logic [9:0] npc,
                       input logic [9:0] off, input logic [31:0] rs);
        step(1, 1, op, npc, off, rs, 0, 0, 0, 0);
    endtask

    task automatic alu(input logic c, input logic z, input logic s);
        step(1, 1, 4'd0, 10'd0, 10'd0, 32'd0, 1, c, z, s);
    endtask

    initial begin
        // Reset held two cycles while a taken b is presented.
        step(0, 1, 4'd1, 10'd100, 10'd5, 32'd0, 1, 1, 1, 1);
        step(0, 1, 4'd1, 10'd100, 10'd5, 32'd0, 1, 1, 1, 1);
        chk("rst_pcsrc", 32'(PCSrc), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_link_we", 32'(link_we), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_cnt", 32'(taken_cnt), 32'd0);
        idle();

        brn(4'd1, 10'd100, 10'h3FB, 32'd0);
        chk("b_pcsrc", 32'(PCSrc), 32'd1);
        chk("b_target", 32'(Ex_NPC), 32'd95);
        chk("b_flush0", 32'(flush), 32'd1);
        chk("b_cnt", 32'(taken_cnt), 32'd1);
        idle();
        chk("b_pcsrc_drop", 32'(PCSrc), 32'd0);
        chk("b_flush1", 32'(flush), 32'd1);
        idle();
        chk("b_flush_end", 32'(flush), 32'd0);

        alu(1, 0, 0);
        brn(4'd7, 10'd20, 10'd4, 32'd0);
        chk("bcy_taken", 32'(PCSrc), 32'd1);
        chk("bcy_target", 32'(Ex_NPC), 32'd24);
        idle(); idle();
        alu(0, 0, 0);
        brn(4'd7, 10'd20, 10'd4, 32'd0);
        chk("bcy_not_taken", 32'(PCSrc), 32'd0);
        chk("bcy_no_flush", 32'(flush), 32'd0);

        brn(4'd4, 10'd50, 10'd3, 32'd0);
        chk("bz_taken", 32'(PCSrc), 32'd1);
        chk("bz_target", 32'(Ex_NPC), 32'd53);
        idle(); idle();
        brn(4'd5, 10'd60, 10'd3, 32'd0);
        chk("bnz_not_taken", 32'(PCSrc), 32'd0);
        brn(4'd3, 10'd200, 10'd1, 32'h8000_0000);
        chk("bltz_taken", 32'(PCSrc), 32'd1);
        chk("bltz_target", 32'(Ex_NPC), 32'd201);
        idle(); idle();
        brn(4'd2, 10'd7, 10'd7, 32'h0000_0ABC);
        chk("br_target", 32'(Ex_NPC), 32'h2BC);
        idle(); idle();

        brn(4'd6, 10'd1020, 10'd10, 32'd0);
        chk("bl_pcsrc", 32'(PCSrc), 32'd1);
        chk("bl_wrap", 32'(Ex_NPC), 32'd6);
        chk("bl_link_we", 32'(link_we), 32'd1);
        chk("bl_link_data", 32'(link_data), 32'd1020);
        idle();
        chk("bl_link_drop", 32'(link_we), 32'd0);
        idle();

        brn(4'd9, 10'd10, 10'd10, 32'd0);
        chk("op9_none", 32'(PCSrc), 32'd0);
        brn(4'd15, 10'd10, 10'd10, 32'd0);
        chk("op15_flush", 32'(flush), 32'd0);

        // Back-to-back: second b and ALU flag writes land in the flush shadow.
        brn(4'd1, 10'd300, 10'd0, 32'd0);
        step(1, 1, 4'd1, 10'd400, 10'd0, 32'd0, 1, 1, 1, 1);
        chk("squash_pcsrc", 32'(PCSrc), 32'd0);
        chk("squash_npc", 32'(Ex_NPC), 32'd300);
        alu(1, 1, 1);
        chk("squash_flags", 32'(flags), 32'd0);
        idle();

        step(1, 0, 4'd1, 10'd5, 10'd5, 32'd0, 1, 1, 1, 1);
        chk("invalid_no_pc", 32'(PCSrc), 32'd0);

        brn(4'd1, 10'd500, 10'd1, 32'd0);
        step(0, 1, 4'd1, 10'd500, 10'd1, 32'd0, 0, 0, 0, 0);
        chk("rst_mid_squash", 32'(flush), 32'd0);
        idle();

        for (int i = 0; i < 17; i++) begin
            brn(4'd1, 10'(i), 10'd1, 32'd0);
            idle(); idle();
        end
        chk("sat_narrow", 32'(taken_cnt_s), 32'hF);
        chk("cnt_wide", 32'(taken_cnt), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage responder for the fetch redirect interface: it drives PCSrc and Ex_NPC back into instruction fetch, which consumes them.
- Evaluates branch ops arriving on the ID/EX boundary against the architectural flags (carry, zero, sign) and the register operand.
- Computes the 10-bit word-address target and issues a one-cycle redirect pulse.
- Squashes wrong-path instructions already in flight and generates the link write for bl.

Parameters:
- AW, 10, instruction word-address width; matches the PC and NPC width.
- FLUSH_CYCLES, 2, number of cycles flush stays high (and valid_in is ignored) after a taken branch; legal range 1..7.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  ID/EX holds a real instruction this cycle.
- id_ex_NPC  in  AW  PC+1 of the instruction in EX.
- br_op  in  4  0 none, 1 b, 2 br, 3 bltz, 4 bz, 5 bnz, 6 bl, 7 bcy, 8 bncy; 9..15 treated as none.
- br_offset  in  AW  signed word offset, two's complement.
- rs_val  in  32  register operand for br/bltz/bz/bnz.
- alu_flag_we  in  1  ALU instruction in EX updates flags.
- alu_carry, alu_zero, alu_sign  in  1 each  flag values from the ALU.
- PCSrc  out  1  redirect fetch this cycle.
- Ex_NPC  out  AW  redirect target, valid while PCSrc=1.
- flush  out  1  invalidate IF/ID and ID/EX contents.
- link_we  out  1  write return address to r31.
- link_data  out  AW  return address (NPC of the bl).
- flags  out  3  {carry, zero, sign} architectural flag register.
- taken_cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (rst=0 at a rising edge) sets every output to 0, including flags, taken_cnt and the squash counter. Reset mid-squash aborts the squash immediately.
- Qualification: act = valid_in & ~flush.
  - With flush high, valid_in is ignored: no flag update, no branch, no link write.
- Taken rules, evaluated on registered flags and current rs_val:
  - b, br, bl: always taken.
  - bltz: taken when rs_val[31]=1.
  - bz: taken when rs_val==0.
  - bnz: taken when rs_val!=0.
  - bcy: taken when carry=1.
  - bncy: taken when carry=0.
- Target calculation:
  - br: target = rs_val[AW-1:0].
  - All other ops: target = id_ex_NPC + br_offset, modulo 2^AW. Wrap-around is silent (e.g. 1020+10 -> 6).
- Latency: all outputs are registered, so a decision made at edge N is visible after edge N, for one cycle.
- Taken branch (act & taken):
  - PCSrc=1 and Ex_NPC=target for exactly one cycle; PCSrc returns to 0 the next cycle unless a new decision is made.
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles, starting in the same cycle as PCSrc. An internal down-counter loads FLUSH_CYCLES and flush = (counter != 0).
  - taken_cnt increments, saturating at all-ones.
- Not-taken branch or non-branch: PCSrc=0. Ex_NPC holds its last value.
- bl: link_we=1 and link_data=id_ex_NPC for one cycle whenever act and br_op=6, coincident with PCSrc.
- Flags:
  - Updated at the edge when act & alu_flag_we.
  - A branch evaluated in the same cycle uses the pre-update (registered) flags. The design is single-issue, so this cannot arise legally; the behaviour is defined anyway.
- Unused br_op codes 9..15 behave as none: no PCSrc, no flush, no link.
- Back-to-back branches: the second branch arrives during flush, so it is squashed. It produces no redirect and its taken condition is never evaluated.
- valid_in=0: no state changes except the squash counter decrementing.

Test Plan:
- Reset: hold rst=0 for 2 cycles with valid_in=1, br_op=1 -> PCSrc, flush, link_we, flags and taken_cnt all read 0.
- Unconditional b: id_ex_NPC=100, br_offset=-5 (0x3FB) -> one cycle later PCSrc=1 and Ex_NPC=95 for one cycle; flush high for exactly 2 cycles; taken_cnt=1.
- Flag branch: ALU op with alu_carry=1, then bcy at NPC=20, offset=4 -> PCSrc=1, Ex_NPC=24. Repeat with carry=0 -> PCSrc stays 0 and flush stays 0.
- Register branches:
  - bz with rs_val=0 -> taken.
  - bnz with rs_val=0 -> not taken.
  - bltz with rs_val=0x80000000 -> taken.
  - br with rs_val=0x0000_0ABC -> Ex_NPC=0x2BC.
- bl with wrap-around: NPC=1020, offset=10 -> Ex_NPC=6; link_we=1 and link_data=1020, same cycle as PCSrc.
- Squash and saturation:
  - Taken b immediately followed by another taken b and an ALU op with flag_we -> second branch gives no PCSrc and flags are unchanged.
  - Preload taken_cnt to 0xFFFF (force or 65535 branches), then one more taken branch -> taken_cnt stays 0xFFFF.
